// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
//   Bundles the two handshakes of the immediate generator stage.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. A producer that raises valid holds valid and
//   its payload stable until that transfer. ready may change freely and never
//   depends on valid within the same cycle.
//
//   Upstream   : in_valid, in_ready, in_inst[31:0]
//   Downstream : out_valid, out_ready, out_imm[XLEN-1:0], out_fmt[2:0],
//                out_illegal
//
//   slave  : the stage itself (consumes instructions, produces results)
//   master : whoever drives instructions in and drains results out
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   One-stage RISC-V immediate generator. The instruction word is decoded
//   combinationally, the extended immediate plus its format code and an
//   illegal-opcode flag are registered, and the result is presented on a
//   valid/ready output. A skid register lets the stage absorb one extra
//   instruction while the consumer stalls, so in_ready can be a pure flop.
//
//   Parameters
//     XLEN     datapath width, 32 or 64
//     EN_ZIMM  1 enables the CSR zimm (fmt Z) decode
//     CNT_W    width of the backpressure counter
//
//   Ports
//     clk        sole clock, rising edge
//     rst_n      asynchronous active-low reset
//     flush      synchronous flush: drops everything held, ignores in_valid
//     bus        imm_gen_pipe_if.slave (in_* / out_* handshakes)
//     cnt_clr    clears stall_cnt (dominates the increment)
//     stall_cnt  cycles seen with out_valid && !out_ready, saturating
//
//   Format codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SHAMT
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  imm_gen_pipe_if.slave      bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cnt
);

  // ---------------------------------------------------------------------------
  // Opcodes and format codes
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPI    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPI32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_Z     = 3'd6,
    FMT_SHAMT = 3'd7
  } fmt_e;

  localparam bit IS_RV64 = (XLEN == 64);

  // ---------------------------------------------------------------------------
  // Width helpers. Every immediate is first assembled as a 32-bit value and
  // then widened to XLEN, which keeps the decode identical for RV32 and RV64.
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [63:0] w;
    w = {{32{v[31]}}, v};
    return w[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [63:0] w;
    w = {32'b0, v};
    return w[XLEN-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [31:0]     imm_i;
  logic [31:0]     imm_s;
  logic [31:0]     imm_b;
  logic [31:0]     imm_u;
  logic [31:0]     imm_j;
  logic [31:0]     shamt5;
  logic [31:0]     shamt6;
  logic [31:0]     zimm;

  logic [XLEN-1:0] d_imm;
  fmt_e            d_fmt;
  logic            d_ill;

  assign inst     = bus.in_inst;
  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  // SLLI (001) and SRLI/SRAI (101) carry a shift amount, not an immediate.
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt5 = {27'b0, inst[24:20]};
  assign shamt6 = {26'b0, inst[25:20]};
  assign zimm   = {27'b0, inst[19:15]};

  always_comb begin
    d_fmt = FMT_NONE;
    d_imm = '0;
    d_ill = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        d_fmt = FMT_I;
        d_imm = sext32(imm_i);
      end
      OPC_OPI: begin
        if (is_shift) begin
          d_fmt = FMT_SHAMT;
          // RV64 shifts take a 6-bit amount; RV32 only 5 bits.
          d_imm = IS_RV64 ? zext32(shamt6) : zext32(shamt5);
        end else begin
          d_fmt = FMT_I;
          d_imm = sext32(imm_i);
        end
      end
      OPC_OPI32: begin
        if (!IS_RV64) begin
          d_ill = 1'b1;
        end else if (is_shift) begin
          // Word shifts on RV64 still use a 5-bit amount.
          d_fmt = FMT_SHAMT;
          d_imm = zext32(shamt5);
        end else begin
          d_fmt = FMT_I;
          d_imm = sext32(imm_i);
        end
      end
      OPC_STORE: begin
        d_fmt = FMT_S;
        d_imm = sext32(imm_s);
      end
      OPC_BRANCH: begin
        d_fmt = FMT_B;
        d_imm = sext32(imm_b);
      end
      OPC_LUI, OPC_AUIPC: begin
        d_fmt = FMT_U;
        d_imm = sext32(imm_u);
      end
      OPC_JAL: begin
        d_fmt = FMT_J;
        d_imm = sext32(imm_j);
      end
      OPC_SYSTEM: begin
        // CSRR*I variants (funct3 101/110/111) carry a 5-bit zimm.
        if (EN_ZIMM && funct3[2] && (funct3[1:0] != 2'b00)) begin
          d_fmt = FMT_Z;
          d_imm = zext32(zimm);
        end
      end
      OPC_OP, OPC_FENCE: begin
        d_fmt = FMT_NONE;
      end
      OPC_OP32: begin
        d_ill = !IS_RV64;
      end
      default: begin
        d_ill = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main + skid buffering
  //   main holds the result on the output; skid catches one more result when
  //   an instruction is accepted while main is stalled. in_ready is simply the
  //   inverse of the skid flop, so it never depends on out_ready combinationally.
  // ---------------------------------------------------------------------------
  logic            main_valid;
  logic [XLEN-1:0] main_imm;
  fmt_e            main_fmt;
  logic            main_ill;

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  fmt_e            skid_fmt;
  logic            skid_ill;

  logic            accept;

  assign accept = bus.in_valid && !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_fmt   <= FMT_NONE;
      main_ill   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_NONE;
      skid_ill   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Skid full implies main full and in_ready low: only draining can occur.
      if (bus.out_ready) begin
        main_imm   <= skid_imm;
        main_fmt   <= skid_fmt;
        main_ill   <= skid_ill;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || bus.out_ready) begin
        main_valid <= 1'b1;
        main_imm   <= d_imm;
        main_fmt   <= d_fmt;
        main_ill   <= d_ill;
      end else begin
        skid_valid <= 1'b1;
        skid_imm   <= d_imm;
        skid_fmt   <= d_fmt;
        skid_ill   <= d_ill;
      end
    end else if (bus.out_ready) begin
      main_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = !skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_imm;
  assign bus.out_fmt     = main_fmt;
  assign bus.out_illegal = main_ill;

  // ---------------------------------------------------------------------------
  // Backpressure counter: counts stalled output cycles, saturates, and is
  // frozen on a flush cycle. A clear always wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (!flush && main_valid && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Drives an RV32 instance (CNT_W=16) and an RV64 instance (CNT_W=4) with the
//   same stimulus. The reference is a depth-2 FIFO of accepted instruction
//   words plus an arithmetic decoder that computes each immediate from the
//   instruction fields with integer math.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Shared drivers and DUTs
  // ---------------------------------------------------------------------------
  logic        drv_valid = 1'b0;
  logic [31:0] drv_inst  = '0;
  logic        drv_ordy  = 1'b0;
  logic        drv_flush = 1'b0;
  logic        drv_clr   = 1'b0;

  logic [15:0] stall32;
  logic [3:0]  stall64;

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();

  assign if32.in_valid  = drv_valid;
  assign if32.in_inst   = drv_inst;
  assign if32.out_ready = drv_ordy;
  assign if64.in_valid  = drv_valid;
  assign if64.in_inst   = drv_inst;
  assign if64.out_ready = drv_ordy;

  imm_gen_pipe #(.XLEN(32), .EN_ZIMM(1'b1), .CNT_W(16)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (drv_flush),
    .bus       (if32),
    .cnt_clr   (drv_clr),
    .stall_cnt (stall32)
  );

  imm_gen_pipe #(.XLEN(64), .EN_ZIMM(1'b1), .CNT_W(4)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (drv_flush),
    .bus       (if64),
    .cnt_clr   (drv_clr),
    .stall_cnt (stall64)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          cnt32_m;
  int          cnt64_m;
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: returns {illegal, fmt[2:0], imm[63:0]}.
  function automatic logic [67:0] ref_dec(input logic [31:0] inst, input int xlen);
    longint      v;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    op  = inst[6:0];
    f3  = inst[14:12];
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (op)
      7'h03, 7'h67: begin
        fmt = 3'd1;
        v = longint'(inst[31:20]);
        if (inst[31]) v -= 4096;
      end
      7'h13, 7'h1B: begin
        if (op == 7'h1B && xlen == 32) begin
          ill = 1'b1;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = 3'd7;
          if (op == 7'h13 && xlen == 64) v = longint'(inst[25:20]);
          else v = longint'(inst[24:20]);
        end else begin
          fmt = 3'd1;
          v = longint'(inst[31:20]);
          if (inst[31]) v -= 4096;
        end
      end
      7'h23: begin
        fmt = 3'd2;
        v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
        if (inst[31]) v -= 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
        if (inst[31]) v -= 4096;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(inst[31:12]) * 4096;
        if (inst[31]) v -= 64'sh1_0000_0000;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        if (inst[31]) v -= 1048576;
      end
      7'h73: begin
        if (f3 >= 3'd5) begin
          fmt = 3'd6;
          v = longint'(inst[19:15]);
        end
      end
      7'h33, 7'h0F: ;
      7'h3B: ill = (xlen == 32);
      default: ill = 1'b1;
    endcase
    imm = v;
    if (xlen == 32) imm[63:32] = 32'b0;
    return {ill, fmt, imm};
  endfunction

  // Advance the reference by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit acc;
    bit pop;
    acc = drv_valid && (exp_q.size() < 2) && !drv_flush;
    pop = (exp_q.size() > 0) && drv_ordy;
    if (drv_clr) begin
      cnt32_m = 0;
      cnt64_m = 0;
    end else if (!drv_flush && exp_q.size() > 0 && !drv_ordy) begin
      if (cnt32_m < 65535) cnt32_m++;
      if (cnt64_m < 15) cnt64_m++;
    end
    if (drv_flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(drv_inst);
    end
  endtask

  task automatic check_all();
    logic [67:0] e32;
    logic [67:0] e64;
    check_eq("valid32", 64'(if32.out_valid), 64'(exp_q.size() > 0));
    check_eq("valid64", 64'(if64.out_valid), 64'(exp_q.size() > 0));
    check_eq("ready32", 64'(if32.in_ready), 64'(exp_q.size() < 2));
    check_eq("ready64", 64'(if64.in_ready), 64'(exp_q.size() < 2));
    check_eq("stall32", 64'(stall32), 64'(cnt32_m));
    check_eq("stall64", 64'(stall64), 64'(cnt64_m));
    if (exp_q.size() > 0) begin
      e32 = ref_dec(exp_q[0], 32);
      e64 = ref_dec(exp_q[0], 64);
      check_eq("imm32", {32'b0, if32.out_imm}, e32[63:0]);
      check_eq("fmt32", 64'(if32.out_fmt), 64'(e32[66:64]));
      check_eq("ill32", 64'(if32.out_illegal), 64'(e32[67]));
      check_eq("imm64", if64.out_imm, e64[63:0]);
      check_eq("fmt64", 64'(if64.out_fmt), 64'(e64[66:64]));
      check_eq("ill64", 64'(if64.out_illegal), 64'(e64[67]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, step the model, check after the edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic v, input logic [31:0] inst, input logic ordy,
                     input logic fl, input logic clr);
    drv_valid = v;
    drv_inst  = inst;
    drv_ordy  = ordy;
    drv_flush = fl;
    drv_clr   = clr;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_v32"}, 64'(if32.out_valid), 64'd0);
    check_eq({tag, "_v64"}, 64'(if64.out_valid), 64'd0);
    check_eq({tag, "_r32"}, 64'(if32.in_ready), 64'd1);
    check_eq({tag, "_r64"}, 64'(if64.in_ready), 64'd1);
    check_eq({tag, "_i32"}, 64'(if32.out_imm), 64'd0);
    check_eq({tag, "_i64"}, if64.out_imm, 64'd0);
    check_eq({tag, "_f32"}, 64'(if32.out_fmt), 64'd0);
    check_eq({tag, "_l64"}, 64'(if64.out_illegal), 64'd0);
    check_eq({tag, "_s32"}, 64'(stall32), 64'd0);
    check_eq({tag, "_s64"}, 64'(stall64), 64'd0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[15];
    logic [31:0] r;
    ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h7F, 7'h00};
    r = $urandom();
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 14)]};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Asynchronous reset before the first clock edge.
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    exp_q.delete();
    cnt32_m = 0;
    cnt64_m = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Known-answer vectors.
    cyc(1'b1, 32'hFFF00093, 1'b1, 1'b0, 1'b0);
    check_eq("addi_v", 64'(if32.out_valid), 64'd1);
    check_eq("addi_imm", 64'(if32.out_imm), 64'hFFFF_FFFF);
    check_eq("addi_fmt", 64'(if32.out_fmt), 64'd1);
    cyc(1'b1, 32'hFE000EE3, 1'b1, 1'b0, 1'b0);
    check_eq("beq_imm", 64'(if32.out_imm), 64'hFFFF_FFFC);
    check_eq("beq_fmt", 64'(if32.out_fmt), 64'd3);
    cyc(1'b1, 32'h4030D093, 1'b1, 1'b0, 1'b0);
    check_eq("srai_imm", 64'(if32.out_imm), 64'd3);
    check_eq("srai_fmt", 64'(if32.out_fmt), 64'd7);
    cyc(1'b1, 32'h800000B7, 1'b1, 1'b0, 1'b0);
    check_eq("lui64_imm", if64.out_imm, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui64_fmt", 64'(if64.out_fmt), 64'd4);
    cyc(1'b1, 32'h300FD073, 1'b1, 1'b0, 1'b0);
    check_eq("csrrwi_imm", if64.out_imm, 64'h1F);
    check_eq("csrrwi_fmt", 64'(if64.out_fmt), 64'd6);
    cyc(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0);
    check_eq("bad_ill", 64'(if32.out_illegal), 64'd1);
    check_eq("bad_fmt", 64'(if32.out_fmt), 64'd0);
    check_eq("bad_imm", 64'(if32.out_imm), 64'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Three back-to-back inputs into a stalled consumer for five stall cycles.
    cyc(1'b1, 32'hFFF00093, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00700093, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("stall5_cnt", 64'(stall32), 64'd5);
    check_eq("stall5_rdy", 64'(if32.in_ready), 64'd0);
    check_eq("stall5_head", 64'(if32.out_imm), 64'hFFFF_FFFF);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("rel_2nd", 64'(if32.out_imm), 64'd5);
    check_eq("rel_rdy", 64'(if32.in_ready), 64'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("rel_empty", 64'(if32.out_valid), 64'd0);

    // Flush with both registers occupied.
    cyc(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00200093, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00300093, 1'b0, 1'b1, 1'b0);
    check_eq("flush_v", 64'(if32.out_valid), 64'd0);
    check_eq("flush_r", 64'(if32.in_ready), 64'd1);

    // Asynchronous reset in the middle of a stall.
    cyc(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00200093, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rstmid");
    exp_q.delete();
    cnt32_m = 0;
    cnt64_m = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Saturation of the 4-bit counter on the RV64 instance.
    cyc(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("sat64", 64'(stall64), 64'd15);
    check_eq("nosat32", 64'(stall32), 64'd20);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("clr_win", 64'(stall64), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32, 64.
REQ-002 SHALL have parameter EN_ZIMM, default 1, enabling the CSR zimm format.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  in  1  synchronous pipeline flush.
REQ-007 SHALL have port in_valid  in  1  instruction valid.
REQ-008 SHALL have port in_ready  out  1  stage can accept.
REQ-009 SHALL have port in_inst  in  32  RV instruction word.
REQ-010 SHALL have port out_valid  out  1  result valid.
REQ-011 SHALL have port out_ready  in  1  consumer accepts.
REQ-012 SHALL have port out_imm  out  XLEN  extended immediate.
REQ-013 SHALL have port out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SHAMT.
REQ-014 SHALL have port out_illegal  out  1  unrecognised opcode.
REQ-015 SHALL have port cnt_clr  in  1  clears stall counter.
REQ-016 SHALL have port stall_cnt  out  CNT_W  backpressure cycle count.

Function
REQ-017 Decode SHALL be combinational on in_inst; result SHALL be registered, latency 1 cycle from input handshake to out_valid.
REQ-018 LOAD 0000011, JALR 1100111, OPI 0010011 (funct3 not 001/101) SHALL give fmt I, imm = sext(inst[31:20]).
REQ-019 OPI funct3 001/101 SHALL give fmt SHAMT, imm = zext(inst[24:20]) for XLEN=32, zext(inst[25:20]) for XLEN=64.
REQ-020 STORE 0100011 SHALL give fmt S, imm = sext({inst[31:25],inst[11:7]}).
REQ-021 BRANCH 1100011 SHALL give fmt B, imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
REQ-022 LUI 0110111, AUIPC 0010111 SHALL give fmt U, imm = sext({inst[31:12],12'b0}) to XLEN.
REQ-023 JAL 1101111 SHALL give fmt J, imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
REQ-024 SYSTEM 1110011 funct3 101/110/111 with EN_ZIMM=1 SHALL give fmt Z, imm = zext(inst[19:15]); otherwise fmt NONE, imm 0.
REQ-025 XLEN=64 only: OPI-32 0011011 SHALL decode as OPI (shamt width 5); with XLEN=32 it SHALL be illegal.
REQ-026 OP 0110011, OP-32 (XLEN=64), FENCE 0001111 SHALL give fmt NONE, imm 0, illegal 0; any other opcode SHALL give fmt NONE, imm 0, illegal 1.
REQ-027 Buffering SHALL be main register plus one skid register; in_ready SHALL be registered and equal !skid_valid.
REQ-028 Accept (in_valid && in_ready) with main empty or out_ready=1 and skid empty SHALL load main; with main valid and out_ready=0 SHALL load skid.
REQ-029 Output handshake with skid valid SHALL move skid to main same edge; in_ready SHALL rise next cycle.
REQ-030 out_imm/out_fmt/out_illegal SHALL hold stable while out_valid && !out_ready; no result SHALL be dropped, duplicated or reordered.
REQ-031 flush SHALL clear main and skid valid next edge, ignore in_valid that cycle, leave stall_cnt unchanged.
REQ-032 stall_cnt SHALL increment each cycle out_valid && !out_ready, saturating at 2^CNT_W-1; cnt_clr SHALL win over increment (result 0).

Reset
REQ-033 rst_n low SHALL immediately force out_valid 0, skid empty, in_ready 1, out_imm 0, out_fmt 0, out_illegal 0, stall_cnt 0, regardless of clk, including mid-transfer.

Verification
REQ-034 0xFFF00093 (ADDI -1), out_ready=1 -> next cycle out_valid 1, out_imm 0xFFFFFFFF, fmt 1.
REQ-035 0xFE000EE3 (BEQ -4) -> out_imm 0xFFFFFFFC, fmt 3; 0x4030D093 (SRAI 3) -> out_imm 0x3, fmt 7.
REQ-036 XLEN=64, 0x800000B7 (LUI) -> out_imm 0xFFFFFFFF80000000, fmt 4; 0x300FD073 (CSRRWI) -> out_imm 0x1F, fmt 6.
REQ-037 out_ready=0 for 5 cycles with 3 back-to-back inputs -> 2 captured, in_ready 0, stall_cnt 5; release -> both results in order.
REQ-038 flush with both registers full -> out_valid 0, in_ready 1 next cycle; rst_n pulse mid-stall -> all outputs per REQ-033 asynchronously.
REQ-039 Opcode 0x7F -> out_illegal 1, fmt 0, imm 0; stall_cnt with CNT_W=4 held stalled 20 cycles -> 15.
